// File: rtl/wide_reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wide_reduce_pipe
//  Description : Three-stage framed wide reduction (AND / OR / EQ) across
//                multi-word frames, fixed latency, no backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_reduce_pipe #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] cmp,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] dout_words
);

    localparam int               c_NCHUNK   = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int               c_PADW     = c_NCHUNK * CHUNK;
    localparam logic             c_INV_IN   = (MODE != 0);
    localparam logic             c_USE_CMP  = (MODE == 2);
    localparam logic             c_INV_OUT  = (MODE == 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [0:0]       c_ST_IDLE  = 1'b0;
    localparam logic [0:0]       c_ST_ACCUM = 1'b1;

    // Every mode is mapped into an AND domain: OR becomes AND of ~din,
    // EQ becomes AND of the bitwise XNOR with cmp.
    logic [WIDTH-1:0] w_m;
    assign w_m = (din ^ (cmp & {WIDTH{c_USE_CMP}})) ^ {WIDTH{c_INV_IN}};

    logic             r_s1_valid;
    logic             r_s1_last;
    logic [WIDTH-1:0] r_s1_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= din_valid;
            r_s1_last  <= din_valid & din_last;
        end
    end

    always_ff @(posedge clk) begin
        if (din_valid) begin
            r_s1_m <= w_m;
        end
    end

    // Bits beyond WIDTH in the last chunk are neutral ones.
    logic [c_PADW-1:0]   w_pad;
    logic [c_NCHUNK-1:0] w_chunk;

    always_comb begin
        w_pad              = '1;
        w_pad[WIDTH-1:0]   = r_s1_m;
    end

    generate
        for (genvar gi = 0; gi < c_NCHUNK; gi++) begin : g_chunk
            assign w_chunk[gi] = &w_pad[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic                r_s2_valid;
    logic                r_s2_last;
    logic [c_NCHUNK-1:0] r_s2_chunk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_s2_chunk <= w_chunk;
        end
    end

    logic             w_word;
    logic             w_acc_next;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [0:0]       r_state;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_dout_valid;
    logic [CNT_W-1:0] r_dout_words;

    assign w_word     = &r_s2_chunk;
    assign w_acc_next = r_acc & w_word;
    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_acc        <= 1'b1;
            r_cnt        <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_words <= '0;
        end else begin
            r_dout_valid <= 1'b0;
            if (r_s2_valid) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (r_s2_last) begin
                            r_dout       <= w_word ^ c_INV_OUT;
                            r_dout_words <= c_CNT_ONE;
                            r_dout_valid <= 1'b1;
                        end else begin
                            r_acc   <= w_word;
                            r_cnt   <= c_CNT_ONE;
                            r_state <= c_ST_ACCUM;
                        end
                    end
                    c_ST_ACCUM: begin
                        if (r_s2_last) begin
                            r_dout       <= w_acc_next ^ c_INV_OUT;
                            r_dout_words <= w_cnt_inc;
                            r_dout_valid <= 1'b1;
                            r_acc        <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= c_ST_IDLE;
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_words = r_dout_words;

endmodule
`default_nettype wire

// File: tb/tb_wide_reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_reduce_pipe
//  Description : Scoreboard bench for wide_reduce_pipe across five configs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_reduce_pipe;

    localparam int c_NDUT = 5;
    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic [63:0] din;
    logic [63:0] cmp;
    logic        last;
    logic [c_NDUT-1:0] vld;

    logic       dv [c_NDUT];
    logic       dq [c_NDUT];
    logic [7:0] dw [c_NDUT];

    logic [7:0] w0, w1, w2, w3;
    logic [1:0] w4;

    typedef struct {
        int         id;
        logic       d;
        logic [7:0] w;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0: AND W64, u1: AND W40 (padded), u2: OR, u3: EQ, u4: AND with CNT_W=2
    wide_reduce_pipe #(.WIDTH(64), .CHUNK(16), .MODE(0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .din(din), .cmp(cmp), .din_valid(vld[0]),
        .din_last(last), .dout(dq[0]), .dout_valid(dv[0]), .dout_words(w0));
    wide_reduce_pipe #(.WIDTH(40), .CHUNK(16), .MODE(0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .din(din[39:0]), .cmp(cmp[39:0]), .din_valid(vld[1]),
        .din_last(last), .dout(dq[1]), .dout_valid(dv[1]), .dout_words(w1));
    wide_reduce_pipe #(.WIDTH(64), .CHUNK(16), .MODE(1), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .din(din), .cmp(cmp), .din_valid(vld[2]),
        .din_last(last), .dout(dq[2]), .dout_valid(dv[2]), .dout_words(w2));
    wide_reduce_pipe #(.WIDTH(64), .CHUNK(16), .MODE(2), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .din(din), .cmp(cmp), .din_valid(vld[3]),
        .din_last(last), .dout(dq[3]), .dout_valid(dv[3]), .dout_words(w3));
    wide_reduce_pipe #(.WIDTH(64), .CHUNK(16), .MODE(0), .CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .din(din), .cmp(cmp), .din_valid(vld[4]),
        .din_last(last), .dout(dq[4]), .dout_valid(dv[4]), .dout_words(w4));

    assign dw[0] = w0;
    assign dw[1] = w1;
    assign dw[2] = w2;
    assign dw[3] = w3;
    assign dw[4] = {6'b0, w4};

    task automatic send(input int k, input logic [63:0] d, input logic [63:0] c,
                        input logic l);
        @(negedge clk);
        din    = d;
        cmp    = c;
        last   = l;
        vld    = '0;
        vld[k] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld  = '0;
            last = 1'b0;
        end
    endtask

    task automatic push(input int k, input logic d, input logic [7:0] w);
        exp_t e;
        e.id = k;
        e.d  = d;
        e.w  = w;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < c_NDUT; k++) begin
                if (dv[k] === 1'b1) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_pulse dut%0d: got dout=%0b words=%0d, required no pulse",
                                 k, dq[k], dw[k]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.id != k || dq[k] !== e.d || dw[k] !== e.w) begin
                            n_err++;
                            $display("FAIL pulse dut%0d: got dout=%0b words=%0d, required dut%0d dout=%0b words=%0d",
                                     k, dq[k], dw[k], e.id, e.d, e.w);
                        end
                    end
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        vld   = '0;
        last  = 1'b0;
        din   = '0;
        cmp   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < c_NDUT; k++) begin
            chk($sformatf("reset_valid_dut%0d", k), {7'b0, dv[k]}, 8'd0);
            chk($sformatf("reset_dout_dut%0d", k), {7'b0, dq[k]}, 8'd0);
            chk($sformatf("reset_words_dut%0d", k), dw[k], 8'd0);
        end

        // single-beat AND frames, including padded 40-bit width
        push(0, 1'b1, 8'd1); send(0, c_ONES, '0, 1'b1);
        push(0, 1'b0, 8'd1); send(0, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b1);
        push(1, 1'b1, 8'd1); send(1, 64'h0000_00FF_FFFF_FFFF, '0, 1'b1);
        push(1, 1'b0, 8'd1); send(1, 64'hFFFF_FF7F_FFFF_FFFF, '0, 1'b1);
        idle(6);
        chk("hold_dout_dut0", {7'b0, dq[0]}, 8'd0);
        chk("hold_words_dut0", dw[0], 8'd1);

        // 4-beat frame with bubbles, bit 37 clear in beat 2
        send(0, c_ONES, '0, 1'b0); idle(2);
        send(0, 64'hFFFF_FFDF_FFFF_FFFF, '0, 1'b0); idle(1);
        send(0, c_ONES, '0, 1'b0); idle(3);
        push(0, 1'b0, 8'd4); send(0, c_ONES, '0, 1'b1);
        send(0, c_ONES, '0, 1'b0);
        push(0, 1'b1, 8'd2); send(0, c_ONES, '0, 1'b1);
        idle(6);

        // OR mode
        send(2, '0, '0, 1'b0); send(2, '0, '0, 1'b0);
        push(2, 1'b0, 8'd3); send(2, '0, '0, 1'b1);
        send(2, '0, '0, 1'b0); send(2, '0, '0, 1'b0);
        push(2, 1'b1, 8'd3); send(2, 64'h8000_0000_0000_0000, '0, 1'b1);
        idle(6);

        // EQ mode
        push(3, 1'b1, 8'd1); send(3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
        push(3, 1'b0, 8'd1); send(3, 64'h0123_4567_89AB_CDEE, 64'h0123_4567_89AB_CDEF, 1'b1);
        idle(6);

        // back-to-back single-beat frames, then counter saturation
        for (int i = 0; i < 20; i++) begin
            push(0, i[0], 8'd1);
            send(0, i[0] ? c_ONES : 64'h7FFF_FFFF_FFFF_FFFF, '0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) push(4, 1'b1, 8'd3);
            send(4, c_ONES, '0, i == 4);
        end
        idle(6);

        // reset mid-frame; din_valid asserted during rst must be ignored
        send(0, c_ONES, '0, 1'b0);
        send(0, c_ONES, '0, 1'b0);
        @(negedge clk);
        rst  = 1'b1;
        last = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        vld  = '0;
        last = 1'b0;
        idle(5);
        chk("post_rst_dout_dut0", {7'b0, dq[0]}, 8'd0);
        chk("post_rst_words_dut0", dw[0], 8'd0);
        push(0, 1'b1, 8'd1); send(0, c_ONES, '0, 1'b1);
        idle(6);

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
